// File: rtl/pcoeff_result_combiner.sv
// Gathers per-lane pcoeff results with one grab pulse, reduces them
// through a registered adder tree and offers the total on valid/ready.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   lane_avail[LANES]     per-lane result available
//   lane_grab[LANES]      one-cycle grab pulse to enabled lanes
//   lane_sum/lane_count   packed lane results, lane i at [i*W +: W]
//   lane_ecc[LANES]       per-lane ECC flag, OR-ed at grab
//   lane_activity         per-lane activity, summed free-running
//   lane_mask[LANES]      lane enables (PCOEFF_COMBINER_LANE_MASK_EN only)
//   out_valid/out_ready   result handshake
//   out_sum/out_count     totals, widths grow by LG bits
//   out_ecc               captured ECC OR
//   activity_sum          activity total, latency LG+1
//
// Optional feature macro: PCOEFF_COMBINER_LANE_MASK_EN
module pcoeff_result_combiner #(
  parameter  int LANES   = 4,
  parameter  int SUM_W   = 48,
  parameter  int COUNT_W = 13,
  parameter  int ACT_W   = 2,
  localparam int LG      = (LANES > 1) ? $clog2(LANES) : 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES-1:0]           lane_avail,
  output logic [LANES-1:0]           lane_grab,
  input  logic [LANES*SUM_W-1:0]     lane_sum,
  input  logic [LANES*COUNT_W-1:0]   lane_count,
  input  logic [LANES-1:0]           lane_ecc,
  input  logic [LANES*ACT_W-1:0]     lane_activity,
`ifdef PCOEFF_COMBINER_LANE_MASK_EN
  input  logic [LANES-1:0]           lane_mask,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SUM_W+LG-1:0]        out_sum,
  output logic [COUNT_W+LG-1:0]      out_count,
  output logic                       out_ecc,
  output logic [ACT_W+LG-1:0]        activity_sum
);

  localparam int OSW = SUM_W + LG;
  localparam int OCW = COUNT_W + LG;
  localparam int OAW = ACT_W + LG;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRAB,
    S_TREE,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic             avail_all_q, avail_all_d;
  logic             rearm_q, rearm_d;
  logic             ecc_q, ecc_d;
  logic [7:0]       lvl_q, lvl_d;
  logic [LANES-1:0] en;
  logic             any_en;

  logic [OSW-1:0] sum_q  [LANES];
  logic [OSW-1:0] sum_d  [LANES];
  logic [OSW-1:0] sum_nx [LANES];
  logic [OCW-1:0] cnt_q  [LANES];
  logic [OCW-1:0] cnt_d  [LANES];
  logic [OCW-1:0] cnt_nx [LANES];

  logic [OAW-1:0] act_q [LG+1][LANES];
  logic [OAW-1:0] act_d [LG+1][LANES];

`ifdef PCOEFF_COMBINER_LANE_MASK_EN
  logic [LANES-1:0] mask_q, mask_d;

  // Mask follows the port in IDLE and freezes once a grab is decided.
  always_comb begin
    mask_d = mask_q;
    if (state_q == S_IDLE) begin
      mask_d = lane_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign en     = (state_q == S_IDLE) ? lane_mask : mask_q;
  assign any_en = |mask_q;
`else
  assign en     = '1;
  assign any_en = 1'b1;
`endif

  // Masked-off lanes read as available.
  assign avail_all_d = &(lane_avail | ~en);

  // One adder level: node i sums nodes 2i and 2i+1. Nodes past the
  // operand count fall to zero, which pads odd levels.
  for (genvar i = 0; i < LANES; i++) begin : g_lvl
    if (2*i+1 < LANES) begin : g_pair
      assign sum_nx[i] = sum_q[2*i] + sum_q[2*i+1];
      assign cnt_nx[i] = cnt_q[2*i] + cnt_q[2*i+1];
    end else if (2*i < LANES) begin : g_odd
      assign sum_nx[i] = sum_q[2*i];
      assign cnt_nx[i] = cnt_q[2*i];
    end else begin : g_zero
      assign sum_nx[i] = '0;
      assign cnt_nx[i] = '0;
    end
  end

  // Activity: input register, then LG pipelined adder levels.
  for (genvar i = 0; i < LANES; i++) begin : g_act0
    assign act_d[0][i] = OAW'(lane_activity[i*ACT_W +: ACT_W]);
  end

  for (genvar k = 1; k <= LG; k++) begin : g_actk
    for (genvar j = 0; j < LANES; j++) begin : g_actj
      if (2*j+1 < LANES) begin : g_pair
        assign act_d[k][j] = act_q[k-1][2*j] + act_q[k-1][2*j+1];
      end else if (2*j < LANES) begin : g_odd
        assign act_d[k][j] = act_q[k-1][2*j];
      end else begin : g_zero
        assign act_d[k][j] = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rearm_d   = rearm_q;
    ecc_d     = ecc_q;
    lvl_d     = lvl_q;
    lane_grab = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d[i] = sum_q[i];
      cnt_d[i] = cnt_q[i];
    end

    if (!avail_all_q) begin
      rearm_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (avail_all_q && rearm_q && any_en) begin
          state_d = S_GRAB;
        end
      end
      S_GRAB: begin
        lane_grab = en;
        rearm_d   = 1'b0;
        lvl_d     = '0;
        ecc_d     = |(lane_ecc & en);
        for (int i = 0; i < LANES; i++) begin
          sum_d[i] = en[i] ? OSW'(lane_sum[i*SUM_W +: SUM_W]) : '0;
          cnt_d[i] = en[i] ? OCW'(lane_count[i*COUNT_W +: COUNT_W]) : '0;
        end
        state_d = (LG == 0) ? S_OUT : S_TREE;
      end
      S_TREE: begin
        for (int i = 0; i < LANES; i++) begin
          sum_d[i] = sum_nx[i];
          cnt_d[i] = cnt_nx[i];
        end
        lvl_d = lvl_q + 8'd1;
        if (lvl_q == 8'(LG - 1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      avail_all_q <= 1'b0;
      rearm_q     <= 1'b1;
      ecc_q       <= 1'b0;
      lvl_q       <= '0;
      for (int i = 0; i < LANES; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      avail_all_q <= avail_all_d;
      rearm_q     <= rearm_d;
      ecc_q       <= ecc_d;
      lvl_q       <= lvl_d;
      for (int i = 0; i < LANES; i++) begin
        sum_q[i] <= sum_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LG; k++) begin
        for (int j = 0; j < LANES; j++) begin
          act_q[k][j] <= '0;
        end
      end
    end else begin
      for (int k = 0; k <= LG; k++) begin
        for (int j = 0; j < LANES; j++) begin
          act_q[k][j] <= act_d[k][j];
        end
      end
    end
  end

  assign out_valid    = (state_q == S_OUT);
  assign out_sum      = sum_q[0];
  assign out_count    = cnt_q[0];
  assign out_ecc      = ecc_q;
  assign activity_sum = act_q[LG][0];

endmodule

// File: tb/tb_pcoeff_result_combiner.sv
// Self-checking bench for pcoeff_result_combiner, LANES=4.
// Table vectors, handshake/rearm/reset sequences, activity model.
module tb_pcoeff_result_combiner;

  localparam int LANES   = 4;
  localparam int SUM_W   = 48;
  localparam int COUNT_W = 13;
  localparam int ACT_W   = 2;
  localparam int LG      = 2;

  logic                     clk;
  logic                     rst_n;
  logic [LANES-1:0]         lane_avail;
  logic [LANES-1:0]         lane_grab;
  logic [LANES*SUM_W-1:0]   lane_sum;
  logic [LANES*COUNT_W-1:0] lane_count;
  logic [LANES-1:0]         lane_ecc;
  logic [LANES*ACT_W-1:0]   lane_activity;
  logic [LANES-1:0]         lane_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W+LG-1:0]      out_sum;
  logic [COUNT_W+LG-1:0]    out_count;
  logic                     out_ecc;
  logic [ACT_W+LG-1:0]      activity_sum;

  pcoeff_result_combiner #(
    .LANES(LANES), .SUM_W(SUM_W), .COUNT_W(COUNT_W), .ACT_W(ACT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lane_avail(lane_avail),
    .lane_grab(lane_grab),
    .lane_sum(lane_sum),
    .lane_count(lane_count),
    .lane_ecc(lane_ecc),
    .lane_activity(lane_activity),
`ifdef PCOEFF_COMBINER_LANE_MASK_EN
    .lane_mask(lane_mask),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_count(out_count),
    .out_ecc(out_ecc),
    .activity_sum(activity_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][47:0] s;
    logic [3:0][12:0] c;
    logic [3:0]       ecc;
    logic [49:0]      es;
    logic [14:0]      ec;
    logic             ee;
  } vec_t;

  int n_chk;
  int n_fail;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [49:0] ref_sum(input logic [3:0][47:0] s,
                                          input logic [3:0] m);
    logic [63:0] t;
    t = 0;
    for (int i = 0; i < 4; i++) if (m[i]) t += 64'(s[i]);
    return t[49:0];
  endfunction

  function automatic logic [14:0] ref_cnt(input logic [3:0][12:0] c,
                                          input logic [3:0] m);
    int t;
    t = 0;
    for (int i = 0; i < 4; i++) if (m[i]) t += int'(c[i]);
    return 15'(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input logic [3:0] av);
    lane_sum   = v.s;
    lane_count = v.c;
    lane_ecc   = v.ecc;
    lane_avail = av;
  endtask

  task automatic scramble();
    lane_sum   = {$urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom()};
    lane_count = 52'({$urandom(), $urandom()});
    lane_ecc   = 4'($urandom());
  endtask

  // Waits for the grab pulse, holds lane data through the capture edge,
  // then drops avail and garbles the lane data.
  task automatic wait_grab(input string nm, input logic [3:0] exp_g);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (lane_grab != '0) seen = 1'b1;
    end
    chk({nm, "_grab_seen"}, 64'(seen), 64'd1);
    chk({nm, "_grab_lanes"}, 64'(lane_grab), 64'(exp_g));
    step();
    lane_avail = '0;
    scramble();
  endtask

  task automatic wait_valid(input string nm, input vec_t v);
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(LG + 1));
    chk({nm, "_sum"}, 64'(out_sum), 64'(v.es));
    chk({nm, "_count"}, 64'(out_count), 64'(v.ec));
    chk({nm, "_ecc"}, 64'(out_ecc), 64'(v.ee));
  endtask

  task automatic accept(input string nm);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_txn(input string nm, input vec_t v);
    apply(v, 4'b1111);
    wait_grab(nm, 4'b1111);
    wait_valid(nm, v);
    accept(nm);
  endtask

  function automatic vec_t mk(input logic [3:0][47:0] s,
                              input logic [3:0][12:0] c,
                              input logic [3:0] ecc);
    vec_t v;
    v.s   = s;
    v.c   = c;
    v.ecc = ecc;
    v.es  = ref_sum(s, 4'b1111);
    v.ec  = ref_cnt(c, 4'b1111);
    v.ee  = |ecc;
    return v;
  endfunction

  logic [ACT_W+LG-1:0] act_hist [$];

  initial begin
    int g;
    int v;
    logic [3:0][47:0] rs;
    logic [3:0][12:0] rc;
    vec_t w;
    n_chk  = 0;
    n_fail = 0;

    tbl[0].s   = {48'd4, 48'd3, 48'd2, 48'd1};
    tbl[0].c   = {13'd40, 13'd30, 13'd20, 13'd10};
    tbl[0].ecc = 4'b0000;
    tbl[0].es  = 50'd10;
    tbl[0].ec  = 15'd100;
    tbl[0].ee  = 1'b0;
    tbl[1].s   = {4{48'hFFFF_FFFF_FFFF}};
    tbl[1].c   = {4{13'h1FFF}};
    tbl[1].ecc = 4'b0100;
    tbl[1].es  = 50'h3_FFFF_FFFF_FFFC;
    tbl[1].ec  = 15'h7FFC;
    tbl[1].ee  = 1'b1;
    tbl[2].s   = '0;
    tbl[2].c   = '0;
    tbl[2].ecc = 4'b0000;
    tbl[2].es  = '0;
    tbl[2].ec  = '0;
    tbl[2].ee  = 1'b0;
    for (int i = 3; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin
        rs[j] = 48'({$urandom(), $urandom()});
        rc[j] = 13'($urandom());
      end
      tbl[i] = mk(rs, rc, 4'($urandom()));
    end

    rst_n         = 1'b0;
    lane_avail    = '0;
    lane_sum      = '0;
    lane_count    = '0;
    lane_ecc      = '0;
    lane_activity = '0;
    lane_mask     = '1;
    out_ready     = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_grab", 64'(lane_grab), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_ecc", 64'(out_ecc), 64'd0);
    chk("rst_act", 64'(activity_sum), 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i]);
    end

    // Backpressure: lanes re-offer while output is stalled.
    apply(tbl[0], 4'b1111);
    wait_grab("bp1", 4'b1111);
    wait_valid("bp1", tbl[0]);
    g = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) apply(tbl[3], 4'b1111);
      step();
      if (lane_grab != '0) g++;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_sum", 64'(out_sum), 64'(tbl[0].es));
    end
    chk("bp_no_grab", 64'(g), 64'd0);
    accept("bp1");
    wait_grab("bp2", 4'b1111);
    wait_valid("bp2", tbl[3]);
    accept("bp2");

    // Avail held high after grab: exactly one pulse.
    apply(tbl[4], 4'b1111);
    g = 0;
    for (int k = 0; k < 20 && g == 0; k++) begin
      step();
      if (lane_grab != '0) g++;
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (lane_grab != '0) g++;
      out_ready = out_valid;
    end
    out_ready = 1'b0;
    chk("hold_one_grab", 64'(g), 64'd1);
    lane_avail = '0;
    step();
    lane_avail = '1;
    wait_grab("rearm", 4'b1111);
    wait_valid("rearm", tbl[4]);
    accept("rearm");

    // Activity sum: model = plain sum of lanes from LG+1 cycles ago.
    act_hist.delete();
    for (int k = 0; k < 30; k++) begin
      step();
      if (k >= LG + 1) begin
        chk("act_sum", 64'(activity_sum), 64'(act_hist[k-LG-1]));
      end
      lane_activity = 8'($urandom());
      v = 0;
      for (int j = 0; j < 4; j++) v += int'(lane_activity[j*ACT_W +: ACT_W]);
      act_hist.push_back((ACT_W+LG)'(v));
    end
    lane_activity = '0;

    // Reset while the tree is working.
    apply(tbl[5], 4'b1111);
    wait_grab("rstmid", 4'b1111);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_sum", 64'(out_sum), 64'd0);
    chk("rstmid_count", 64'(out_count), 64'd0);
    chk("rstmid_grab", 64'(lane_grab), 64'd0);
    step();
    rst_n = 1'b1;
    g = 0;
    v = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (lane_grab != '0) g++;
      if (out_valid) v++;
    end
    chk("rstmid_no_grab", 64'(g), 64'd0);
    chk("rstmid_no_valid", 64'(v), 64'd0);
    run_txn("after_rst", tbl[6]);

`ifdef PCOEFF_COMBINER_LANE_MASK_EN
    w = tbl[7];
    w.s[2]   = 48'd99;
    w.ecc    = 4'b0100;
    w.es     = ref_sum(w.s, 4'b0011);
    w.ec     = ref_cnt(w.c, 4'b0011);
    w.ee     = 1'b0;
    lane_mask = 4'b0011;
    apply(w, 4'b0011);
    wait_grab("mask", 4'b0011);
    wait_valid("mask", w);
    accept("mask");
    lane_mask  = 4'b0000;
    lane_avail = 4'b1111;
    g = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (lane_grab != '0) g++;
    end
    chk("mask_zero_idle", 64'(g), 64'd0);
    lane_avail = '0;
    lane_mask  = '1;
    step();
`else
    w = tbl[8];
    lane_avail = 4'b0111;
    lane_sum   = w.s;
    g = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (lane_grab != '0) g++;
    end
    chk("partial_avail_idle", 64'(g), 64'd0);
`endif
    run_txn("final", tbl[9]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
